// File: rtl/memresp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package memresp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int CNT_W      = 4;
  localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Request/response handshake bundle between the core (master) and mem_resp_ctrl (slave).
interface mem_resp_ctrl_if;
  logic        req_valid, req_ready, req_wr, perr_inject;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_perr;
  logic [15:0] rsp_rdata;

  modport master (output req_valid, req_wr, req_addr, req_wdata, perr_inject, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr);
  modport slave  (input  req_valid, req_wr, req_addr, req_wdata, perr_inject, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr);
endinterface

// File: rtl/memresp_store.sv
// Word storage: async read, sync write, resettable valid bits.
// MEMRESP_PARITY_EN adds a per-word even-parity bit with injectable corruption.
module memresp_store
  import memresp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  input  logic              inject_i,
  output logic [15:0]       rdata_o,
  output logic              perr_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Data is deliberately not reset; the valid bits alone make words read as 0.
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;

  always_ff @(posedge clk or posedge rst)
    if (rst)       vld_q         <= '0;
    else if (we_i) vld_q[addr_i] <= 1'b1;

  assign rdata_o = vld_q[addr_i] ? mem_q[addr_i] : 16'h0000;

`ifdef MEMRESP_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk)
    if (we_i) par_q[addr_i] <= (^wdata_i) ^ inject_i;

  assign perr_o = vld_q[addr_i] & (par_q[addr_i] != (^mem_q[addr_i]));
`else
  logic unused_inject;
  assign unused_inject = inject_i;
  assign perr_o        = 1'b0;
`endif
endmodule

// File: rtl/mem_resp_ctrl.sv
// Multi-cycle memory responder: accept, wait LATENCY edges, access storage, hold response.
// Optional parity checking is enabled with MEMRESP_PARITY_EN.
module mem_resp_ctrl
  import memresp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = 4
) (
  input logic             clk,
  input logic             rst,
  mem_resp_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d, inj_q, inj_d;
  logic [15:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d, perr_q, perr_d;

  logic              addr_err, access, st_we, st_perr;
  logic [15:0]       st_rdata;

  // Upper address bits are range-checked rather than silently aliased.
  assign addr_err = addr_q[0] | (|addr_q[15:ADDR_W+1]);
  assign access   = (state_q == WAIT) && (cnt_q == '0);
  assign st_we    = access & wr_q & ~addr_err;

  memresp_store #(.ADDR_W(ADDR_W)) u_store (
    .clk      (clk),
    .rst      (rst),
    .we_i     (st_we),
    .addr_i   (addr_q[ADDR_W:1]),
    .wdata_i  (wdata_q),
    .inject_i (inj_q),
    .rdata_o  (st_rdata),
    .perr_o   (st_perr)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    inj_d       = inj_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    perr_d      = perr_q;
    unique case (state_q)
      IDLE: if (bus.req_valid && req_ready_q) begin
        wr_d        = bus.req_wr;
        inj_d       = bus.perr_inject;
        addr_d      = bus.req_addr;
        wdata_d     = bus.req_wdata;
        cnt_d       = CNT_W'(LATENCY - 1);
        req_ready_d = 1'b0;
        state_d     = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        rsp_valid_d = 1'b1;
        err_d       = addr_err;
        rdata_d     = (!wr_q && !addr_err) ? st_rdata : 16'h0000;
        perr_d      = !wr_q && !addr_err && st_perr;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        rdata_d     = 16'h0000;
        err_d       = 1'b0;
        perr_d      = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      inj_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      inj_q       <= inj_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      perr_q      <= perr_d;
    end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_perr  = perr_q;
endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Bench for mem_resp_ctrl: vector table, reset-in-WAIT sequence, random traffic, LATENCY=1 turnaround.
module tb_mem_resp_ctrl;
`ifdef MEMRESP_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT_A = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  mem_resp_ctrl_if a ();
  mem_resp_ctrl_if b ();

  mem_resp_ctrl #(.ADDR_W(10), .LATENCY(LAT_A)) u_a (.clk(clk), .rst(rst), .bus(a));
  mem_resp_ctrl #(.ADDR_W(10), .LATENCY(1))     u_b (.clk(clk), .rst(rst), .bus(b));

  int errors = 0, checks = 0;

  // Reference model: plain word array indexed by byte address / 2.
  logic [15:0] m_data [1024];
  bit          m_vld  [1024];
  bit          m_inj  [1024];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                                input logic inj, output logic [15:0] rd, output logic err,
                                output logic perr);
    int idx;
    idx  = int'(addr) / 2;
    err  = (int'(addr) % 2 != 0) || (int'(addr) >= 2048);
    rd   = 16'h0000;
    perr = 1'b0;
    if (!err) begin
      if (wr) begin
        m_data[idx] = wd; m_vld[idx] = 1'b1; m_inj[idx] = inj;
      end else if (m_vld[idx]) begin
        rd   = m_data[idx];
        perr = PAR && m_inj[idx];
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_vld[i] = 1'b0;
  endtask

  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                     input logic inj, input int hold, input string nm,
                     output logic [15:0] rd, output logic err, output logic perr);
    int lat;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(a.req_ready), 32'd1);
    a.req_valid = 1'b1; a.req_wr = wr; a.req_addr = addr; a.req_wdata = wd;
    a.perr_inject = inj; a.rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    a.req_valid = 1'b0;
    lat = 0;
    while (a.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(LAT_A));
    rd = a.rsp_rdata; err = a.rsp_err; perr = a.rsp_perr;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk({nm, "_hold"}, 32'({a.rsp_valid, a.req_ready, a.rsp_err, a.rsp_perr, a.rsp_rdata}),
          32'({1'b1, 1'b0, err, perr, rd}));
    end
    a.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a.rsp_ready = 1'b0;
    chk({nm, "_done"}, 32'({a.rsp_valid, a.req_ready}), 32'b01);
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [15:0] addr, wd;
    logic        inj;
    int          hold;
    logic [15:0] rd;
    logic        err, perr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic inj, input int hold,
                              input logic [15:0] rd, input logic err, input logic perr);
    vec_t v;
    v.nm = nm; v.wr = wr; v.addr = addr; v.wd = wd; v.inj = inj; v.hold = hold;
    v.rd = rd; v.err = err; v.perr = perr;
    return v;
  endfunction

  logic [15:0] g_rd, e_rd;
  logic        g_err, e_err, g_perr, e_perr;
  logic        bvld [12];
  int          nvalid;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk("rd_unwritten", 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("wr_beef",      1, 16'h0020, 16'hBEEF, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("rd_beef",      0, 16'h0020, 16'h0000, 0, 3, 16'hBEEF, 0, 0));
    tbl.push_back(mk("rd_misalign",  0, 16'h0021, 16'h0000, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk("rd_oor",       0, 16'h0800, 16'h0000, 0, 1, 16'h0000, 1, 0));
    tbl.push_back(mk("wr_oor_odd",   1, 16'h0801, 16'hDEAD, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk("wr_oor",       1, 16'h0800, 16'h7777, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk("rd_alias0",    0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("wr_top",       1, 16'h07FE, 16'hA5A5, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("rd_top",       0, 16'h07FE, 16'h0000, 0, 0, 16'hA5A5, 0, 0));
    tbl.push_back(mk("wr_inj",       1, 16'h0002, 16'h00FF, 1, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("rd_inj",       0, 16'h0002, 16'h0000, 0, 2, 16'h00FF, 0, PAR));
    tbl.push_back(mk("wr_clean",     1, 16'h0004, 16'h0F0F, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("rd_clean",     0, 16'h0004, 16'h0000, 0, 0, 16'h0F0F, 0, 0));

    a.req_valid = 0; a.req_wr = 0; a.req_addr = 0; a.req_wdata = 0; a.perr_inject = 0; a.rsp_ready = 0;
    b.req_valid = 0; b.req_wr = 0; b.req_addr = 0; b.req_wdata = 0; b.perr_inject = 0; b.rsp_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_perr, a.rsp_rdata}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    rst = 1'b0;

    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].inj, e_rd, e_err, e_perr);
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].inj, tbl[i].hold, tbl[i].nm, g_rd, g_err, g_perr);
      chk({tbl[i].nm, "_rsp"}, 32'({g_err, g_perr, g_rd}), 32'({tbl[i].err, tbl[i].perr, tbl[i].rd}));
    end

    // Reset lands during the WAIT of a write: the write must never commit.
    model(1, 16'h0040, 16'h1234, 0, e_rd, e_err, e_perr);
    txn(1, 16'h0040, 16'h1234, 0, 0, "wr_1234", g_rd, g_err, g_perr);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_wr = 1'b1; a.req_addr = 16'h0040; a.req_wdata = 16'h5555;
    @(posedge clk); @(negedge clk);
    a.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_outs", 32'({a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_perr, a.rsp_rdata}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(negedge clk);
    chk("rst_hold_outs", 32'({a.req_ready, a.rsp_valid, a.rsp_rdata}), 32'({1'b1, 1'b0, 16'h0000}));
    rst = 1'b0;
    model_reset();
    model(0, 16'h0040, 16'h0000, 0, e_rd, e_err, e_perr);
    txn(0, 16'h0040, 16'h0000, 0, 0, "rd_after_rst", g_rd, g_err, g_perr);
    chk("rd_after_rst_rsp", 32'({g_err, g_rd}), 32'({1'b0, 16'h0000}));
    chk("rd_after_rst_mdl", 32'({g_err, g_perr, g_rd}), 32'({e_err, e_perr, e_rd}));

    // Random traffic concentrated on a few words, with misaligned and aliasing out-of-range hits.
    for (int n = 0; n < 60; n++) begin
      logic        wr, inj;
      logic [15:0] addr, wd;
      int          r;
      r    = $urandom_range(0, 9);
      if (r == 0)      addr = 16'($urandom_range(0, 15) * 2 + 1);
      else if (r == 1) addr = 16'(16'h0800 + $urandom_range(0, 7) * 2 + ($urandom_range(0, 3) << 12));
      else             addr = 16'($urandom_range(0, 15) * 2);
      wr   = 1'($urandom_range(0, 1));
      wd   = 16'($urandom);
      inj  = ($urandom_range(0, 3) == 0);
      model(wr, addr, wd, inj, e_rd, e_err, e_perr);
      txn(wr, addr, wd, inj, $urandom_range(0, 2), "rand", g_rd, g_err, g_perr);
      chk("rand_rsp", 32'({g_err, g_perr, g_rd}), 32'({e_err, e_perr, e_rd}));
    end

    // LATENCY=1 with both valids held high: one response every 3 edges.
    @(negedge clk);
    b.req_valid = 1'b1; b.req_wr = 1'b0; b.req_addr = 16'h0010; b.rsp_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      bvld[i] = b.rsp_valid;
      if (bvld[i]) nvalid++;
      chk("lat1_pattern", 32'(bvld[i]), 32'((i % 3) == 1));
    end
    chk("lat1_count", 32'(nvalid), 32'd4);
    b.req_valid = 1'b0; b.rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
